// File: rtl/csr_ctrl.sv
// CSR instruction sequencer: read / modify / write / respond, or illegal-instruction trap.
// Optional read-only write trap is compiled in with `define TCORE_CSR_RO_CHECK_EN.
//
// state | meaning
// IDLE  | ready, latch incoming request
// READ  | read old CSR value (suppressed for RW/RWI with rd=0)
// WRITE | write new value (skipped for set/clear with rs1 field 0)
// RESP  | hold writeback response until rsp_ready_i
// TRAP  | one-cycle illegal-instruction trap request
module csr_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [11:0]     req_csr_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic [4:0]      req_rs1_idx_i,
  input  logic [4:0]      req_rd_idx_i,
  input  logic [XLEN-1:0] req_pc_i,
  output logic            csr_rd_en_o,
  output logic            csr_wr_en_o,
  output logic [11:0]     csr_idx_o,
  output logic [XLEN-1:0] csr_wdata_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic [4:0]      rsp_rd_idx_o,
  output logic            trap_active_o,
  output logic [XLEN-1:0] trap_cause_o,
  output logic [XLEN-1:0] trap_mepc_o
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_RESP, S_TRAP} state_e;

  state_e          state_q, state_d;
  logic [1:0]      opk_q;
  logic [11:0]     csr_q;
  logic [XLEN-1:0] opnd_q;
  logic [4:0]      rs1_idx_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] old_q;

  logic illegal, ro_wr, rd_suppress, wr_skip;
  logic [XLEN-1:0] wdata;

`ifdef TCORE_CSR_RO_CHECK_EN
  assign ro_wr = (req_csr_i[11:10] == 2'b11) &&
                 ((req_op_i[1:0] == 2'b01) || (req_op_i[1] && (req_rs1_idx_i != 5'd0)));
`else
  assign ro_wr = 1'b0;
`endif

  assign illegal     = (req_op_i[1:0] == 2'b00) || ro_wr;
  assign rd_suppress = (opk_q == 2'b01) && (rd_q == 5'd0);
  assign wr_skip     = opk_q[1] && (rs1_idx_q == 5'd0);

  always_comb begin
    wdata = '0;
    case (opk_q)
      2'b01:   wdata = opnd_q;
      2'b10:   wdata = old_q | opnd_q;
      2'b11:   wdata = old_q & ~opnd_q;
      default: wdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      opk_q     <= '0;
      csr_q     <= '0;
      opnd_q    <= '0;
      rs1_idx_q <= '0;
      rd_q      <= '0;
      pc_q      <= '0;
      old_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid_i) begin
        opk_q     <= req_op_i[1:0];
        csr_q     <= req_csr_i;
        // I-forms use the rs1 field as a zero-extended immediate
        opnd_q    <= req_op_i[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx_i} : req_rs1_i;
        rs1_idx_q <= req_rs1_idx_i;
        rd_q      <= req_rd_idx_i;
        pc_q      <= req_pc_i;
        old_q     <= '0;
      end
      if (state_q == S_READ) begin
        old_q <= rd_suppress ? '0 : csr_rdata_i;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready_o   = 1'b0;
    csr_rd_en_o   = 1'b0;
    csr_wr_en_o   = 1'b0;
    csr_idx_o     = '0;
    csr_wdata_o   = '0;
    rsp_valid_o   = 1'b0;
    rsp_rdata_o   = '0;
    rsp_rd_idx_o  = '0;
    trap_active_o = 1'b0;
    trap_cause_o  = '0;
    trap_mepc_o   = '0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = illegal ? S_TRAP : S_READ;
      end
      S_READ: begin
        csr_rd_en_o = !rd_suppress;
        csr_idx_o   = csr_q;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        csr_wr_en_o = !wr_skip;
        csr_idx_o   = csr_q;
        csr_wdata_o = wr_skip ? '0 : wdata;
        state_d     = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o  = 1'b1;
        rsp_rdata_o  = old_q;
        rsp_rd_idx_o = rd_q;
        if (rsp_ready_i) state_d = S_IDLE;
      end
      S_TRAP: begin
        trap_active_o = 1'b1;
        trap_cause_o  = XLEN'(2);
        trap_mepc_o   = pc_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed bench for csr_ctrl: CSR op sequences, traps, backpressure and reset abort.
module tb_csr_ctrl;
  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [2:0]      req_op_i;
  logic [11:0]     req_csr_i;
  logic [XLEN-1:0] req_rs1_i;
  logic [4:0]      req_rs1_idx_i;
  logic [4:0]      req_rd_idx_i;
  logic [XLEN-1:0] req_pc_i;
  logic            csr_rd_en_o;
  logic            csr_wr_en_o;
  logic [11:0]     csr_idx_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic [XLEN-1:0] csr_rdata_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [XLEN-1:0] rsp_rdata_o;
  logic [4:0]      rsp_rd_idx_o;
  logic            trap_active_o;
  logic [XLEN-1:0] trap_cause_o;
  logic [XLEN-1:0] trap_mepc_o;

  int n_tests = 0;
  int n_fail  = 0;

  csr_ctrl #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_csr_i(req_csr_i), .req_rs1_i(req_rs1_i),
    .req_rs1_idx_i(req_rs1_idx_i), .req_rd_idx_i(req_rd_idx_i), .req_pc_i(req_pc_i),
    .csr_rd_en_o(csr_rd_en_o), .csr_wr_en_o(csr_wr_en_o), .csr_idx_o(csr_idx_o),
    .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_rd_idx_o(rsp_rd_idx_o),
    .trap_active_o(trap_active_o), .trap_cause_o(trap_cause_o), .trap_mepc_o(trap_mepc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample just after the edge; strobes must stay mutually exclusive.
  task automatic tick();
    @(posedge clk_i);
    #1;
    chk("strobe_excl", 64'($onehot0({csr_rd_en_o, csr_wr_en_o, trap_active_o, rsp_valid_o})), 64'd1);
  endtask

  task automatic set_req(input logic [2:0] op, input logic [11:0] csr, input logic [31:0] rs1,
                         input logic [4:0] idx, input logic [4:0] rd, input logic [31:0] pc);
    req_op_i = op; req_csr_i = csr; req_rs1_i = rs1;
    req_rs1_idx_i = idx; req_rd_idx_i = rd; req_pc_i = pc;
  endtask

  task automatic run_csr(input string tag, input logic [2:0] op, input logic [11:0] csr,
                         input logic [31:0] rs1, input logic [4:0] idx, input logic [4:0] rd,
                         input logic [31:0] old, input logic exp_rd, input logic exp_wr,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    set_req(op, csr, rs1, idx, rd, 32'h200);
    csr_rdata_i = old;
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1;
    chk({tag, "_idle_ready"}, req_ready_o, 1'b1);
    tick();
    req_valid_i = 1'b0;
    chk({tag, "_rd_en"}, csr_rd_en_o, exp_rd);
    if (exp_rd) chk({tag, "_rd_idx"}, csr_idx_o, csr);
    chk({tag, "_rd_ready"}, req_ready_o, 1'b0);
    tick();
    chk({tag, "_wr_en"}, csr_wr_en_o, exp_wr);
    chk({tag, "_wdata"}, csr_wdata_o, exp_wdata);
    tick();
    chk({tag, "_rsp_valid"}, rsp_valid_o, 1'b1);
    chk({tag, "_rsp_rdata"}, rsp_rdata_o, exp_rdata);
    chk({tag, "_rsp_rd"}, rsp_rd_idx_o, rd);
    tick();
    chk({tag, "_back_idle"}, req_ready_o, 1'b1);
    chk({tag, "_rsp_drop"}, rsp_valid_o, 1'b0);
  endtask

  task automatic run_trap(input string tag, input logic [2:0] op, input logic [11:0] csr,
                          input logic [31:0] pc);
    set_req(op, csr, 32'h1234, 5'd1, 5'd3, pc);
    csr_rdata_i = 32'h99;
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    chk({tag, "_active"}, trap_active_o, 1'b1);
    chk({tag, "_cause"}, trap_cause_o, 32'd2);
    chk({tag, "_mepc"}, trap_mepc_o, pc);
    chk({tag, "_no_strobe"}, {csr_rd_en_o, csr_wr_en_o, rsp_valid_o}, 3'b000);
    tick();
    chk({tag, "_one_cycle"}, trap_active_o, 1'b0);
    chk({tag, "_mepc_clr"}, trap_mepc_o, 32'd0);
    chk({tag, "_ready"}, req_ready_o, 1'b1);
    tick();
    chk({tag, "_no_rsp"}, rsp_valid_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; rsp_ready_i = 1'b0; csr_rdata_i = '0;
    set_req(3'b000, 12'h0, 32'h0, 5'd0, 5'd0, 32'h0);
    tick(); tick();
    chk("rst_ready", req_ready_o, 1'b1);
    chk("rst_strobes", {csr_rd_en_o, csr_wr_en_o, rsp_valid_o, trap_active_o}, 4'b0000);
    chk("rst_data", {csr_idx_o, csr_wdata_o, rsp_rdata_o, rsp_rd_idx_o}, '0);
    chk("rst_trap", {trap_cause_o, trap_mepc_o}, 64'd0);
    rst_i = 1'b0;
    tick();

    run_csr("csrrw",  3'b001, 12'h340, 32'hDEADBEEF, 5'd1,  5'd5, 32'h12345678, 1, 1, 32'hDEADBEEF, 32'h12345678);
    run_csr("csrrs",  3'b010, 12'h341, 32'h0F0,      5'd2,  5'd3, 32'h00F,      1, 1, 32'h0FF,      32'h00F);
    run_csr("csrrc",  3'b011, 12'h342, 32'h00F,      5'd4,  5'd6, 32'h0FF,      1, 1, 32'h0F0,      32'h0FF);
    run_csr("csrrsi0",3'b110, 12'h343, 32'hFFFF,     5'd0,  5'd7, 32'hABCD,     1, 0, 32'h0,        32'hABCD);
    run_csr("csrrwi", 3'b101, 12'h305, 32'hFFFF,     5'h1F, 5'd0, 32'h5555,     0, 1, 32'h1F,       32'h0);
    run_csr("csrrci", 3'b111, 12'h300, 32'hFFFF,     5'd3,  5'd8, 32'hF,        1, 1, 32'hC,        32'hF);
    run_csr("ro_rs0", 3'b010, 12'hC00, 32'hFF,       5'd0,  5'd2, 32'h77,       1, 0, 32'h0,        32'h77);
`ifdef TCORE_CSR_RO_CHECK_EN
    run_trap("ro_rw", 3'b001, 12'hC00, 32'h300);
`else
    run_csr("ro_rw",  3'b001, 12'hC00, 32'h55,       5'd1,  5'd4, 32'h66,       1, 1, 32'h55,       32'h66);
`endif
    run_trap("op100", 3'b100, 12'h340, 32'h80);
    run_trap("op000", 3'b000, 12'h340, 32'h84);

    // Backpressure with a second request arriving during the first one.
    set_req(3'b001, 12'h340, 32'h1, 5'd1, 5'd9, 32'h400);
    csr_rdata_i = 32'h42; rsp_ready_i = 1'b0; req_valid_i = 1'b1;
    tick();
    set_req(3'b010, 12'h341, 32'h2, 5'd2, 5'd10, 32'h404);
    chk("bp_read", csr_rd_en_o, 1'b1);
    tick();
    chk("bp_wdata_first", csr_wdata_o, 32'h1);
    csr_rdata_i = 32'h10;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", rsp_valid_o, 1'b1);
      chk("bp_hold_rdata", rsp_rdata_o, 32'h42);
      chk("bp_hold_rd", rsp_rd_idx_o, 5'd9);
      chk("bp_hold_ready", req_ready_o, 1'b0);
      tick();
    end
    chk("bp_still_valid", rsp_valid_o, 1'b1);
    rsp_ready_i = 1'b1;
    tick();
    chk("bp_idle", req_ready_o, 1'b1);
    chk("bp_rsp_drop", rsp_valid_o, 1'b0);
    tick();
    req_valid_i = 1'b0;
    chk("bp2_read", csr_rd_en_o, 1'b1);
    chk("bp2_idx", csr_idx_o, 12'h341);
    tick();
    chk("bp2_wdata", csr_wdata_o, 32'h12);
    tick();
    chk("bp2_rsp", rsp_rdata_o, 32'h10);
    chk("bp2_rd", rsp_rd_idx_o, 5'd10);
    tick();

    // Reset during WRITE aborts the operation.
    set_req(3'b001, 12'h340, 32'hCAFE, 5'd1, 5'd5, 32'h500);
    csr_rdata_i = 32'h1; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    tick();
    chk("rstw_in_write", csr_wr_en_o, 1'b1);
    rst_i = 1'b1;
    tick();
    chk("rstw_no_wr", csr_wr_en_o, 1'b0);
    chk("rstw_ready", req_ready_o, 1'b1);
    rst_i = 1'b0;
    tick();
    chk("rstw_no_wr2", csr_wr_en_o, 1'b0);
    chk("rstw_no_rsp", rsp_valid_o, 1'b0);

    // Reset in RESP drops the pending response.
    rsp_ready_i = 1'b0; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    tick(); tick();
    chk("rstr_in_resp", rsp_valid_o, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rstr_dropped", rsp_valid_o, 1'b0);
    chk("rstr_rdata", rsp_rdata_o, 32'h0);
    tick();
    chk("rstr_ready", req_ready_o, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_ctrl.md
CSR_CTRL -- requirements
Module: csr_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk_i.
REQ-002 Parameter: XLEN, default 32, data width taken from tcore_param.
REQ-003 clk_i  in  1  core clock.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 req_valid_i  in  1  CSR instruction valid; req_ready_o  out  1  block in IDLE.
REQ-006 req_op_i  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
REQ-007 req_csr_i  in  12  CSR address; req_rs1_i  in  XLEN  rs1 value; req_rs1_idx_i  in  5  rs1 field, also uimm for I-forms.
REQ-008 req_rd_idx_i  in  5  destination register; req_pc_i  in  XLEN  instruction PC.
REQ-009 csr_rd_en_o  out  1, csr_wr_en_o  out  1, csr_idx_o  out  12, csr_wdata_o  out  XLEN, csr_rdata_i  in  XLEN: initiator side of the CSR register file port, with combinational read data.
REQ-010 rsp_valid_o  out  1, rsp_ready_i  in  1, rsp_rdata_o  out  XLEN, rsp_rd_idx_o  out  5: writeback response.
REQ-011 trap_active_o  out  1, trap_cause_o  out  XLEN, trap_mepc_o  out  XLEN: illegal-instruction trap request to the CSR file.

Function
REQ-012 FSM states SHALL be IDLE, READ, WRITE, RESP, TRAP; req_ready_o SHALL be 1 only in IDLE.
REQ-013 IDLE: when req_valid_i is high, the block SHALL latch op, csr, operand, rd and pc. Operand = req_rs1_i, or the zero-extended req_rs1_idx_i for I-forms. The next state SHALL be TRAP if the request is illegal, otherwise READ.
REQ-014 READ (one cycle): csr_rd_en_o=1, csr_idx_o=latched csr, and csr_rdata_i SHALL be captured as old. The read SHALL be suppressed (rd_en=0, old=0) for RW/RWI when rd=0.
REQ-015 WRITE (one cycle): csr_wr_en_o=1 with csr_wdata_o set as follows: RW/RWI = operand, RS/RSI = old|operand, RC/RCI = old&~operand.
REQ-016 The write SHALL be skipped (wr_en=0, still one cycle) for RS/RC/RSI/RCI when the rs1 field is 0.
REQ-017 RESP: rsp_valid_o=1, rsp_rdata_o=old, rsp_rd_idx_o=rd. These outputs SHALL be held stable until rsp_ready_i; then the block SHALL return to IDLE.
REQ-018 Latency: a request accepted at edge N SHALL give READ in cycle N+1, WRITE in N+2 and rsp_valid_o in N+3 (minimum).
REQ-019 Illegal: op 000 or 100 SHALL be illegal, and so SHALL the REQ-030 read-only write case.
REQ-020 TRAP (one cycle): trap_active_o=1, trap_cause_o=2, trap_mepc_o=latched pc, with no CSR read or write and no response; the next state SHALL be IDLE.
REQ-021 csr_rd_en_o, csr_wr_en_o, trap_active_o and rsp_valid_o SHALL never be high in the same cycle.
REQ-022 Outside their active states, strobes SHALL be 0, and csr_idx_o/csr_wdata_o/trap_* data SHALL be 0.
REQ-023 A req_valid_i that is high while the block is not in IDLE SHALL be ignored, and its fields SHALL NOT disturb the latched values.

Reset
REQ-024 Reset SHALL force the FSM to IDLE and clear all latched fields.
REQ-025 Reset values: req_ready_o=1; every other output SHALL be 0.
REQ-026 Reset asserted in READ or WRITE SHALL abort the operation, and no csr_wr_en_o SHALL occur in the following cycle.
REQ-027 Reset asserted in RESP SHALL drop the pending response.

Configuration
REQ-028 Macro TCORE_CSR_RO_CHECK_EN SHALL compile the read-only check in or out.
REQ-029 Without the macro, only op 000/100 SHALL trap.
REQ-030 With the macro defined, a request with csr[11:10]==2'b11 and an effective write (RW/RWI always; set/clear forms when rs1 field≠0) SHALL be illegal. A read-only RS/RC with rs1 field=0 SHALL remain legal.

Verification
REQ-031 CSRRW csr=0x340, rs1=0xDEADBEEF, rd=5, old=0x12345678 -> read in N+1, write 0xDEADBEEF in N+2, response 0x12345678 on rd 5 in N+3.
REQ-032 CSRRS rs1=0x0F0 with old 0x00F -> wdata 0x0FF; CSRRC rs1=0x00F with old 0x0FF -> wdata 0x0F0; CSRRSI rs1_idx=0 -> no wr_en, response returns old.
REQ-033 CSRRWI csr=0x305, uimm=0x1F, rd=0 -> no rd_en, write 0x1F, response data 0.
REQ-034 op=100 at pc 0x80 -> exactly one cycle trap_active_o=1 with cause 2 and mepc 0x80, no strobes, no rsp_valid_o.
REQ-035 With TCORE_CSR_RO_CHECK_EN, CSRRW csr=0xC00 -> trap; CSRRS csr=0xC00 with rs1 field 0 -> normal read response. Without the macro, CSRRW csr=0xC00 -> write occurs.
REQ-036 rsp_ready_i held 0 for 3 cycles while a second req_valid_i is pending -> response stable, req_ready_o=0. Then rsp_ready_i=1 -> IDLE and the second request is accepted. Reset during WRITE -> no wr_en afterward, req_ready_o=1.
